// File: rtl/ysyx_22050710_sram_arb_pkg.sv
// ysyx_22050710_sram_arb_pkg: shared types and constants for the instruction SRAM
// read-port arbiter (FSM states, requester IDs, grant decode helper).
package ysyx_22050710_sram_arb_pkg;

   // Arbiter FSM: IDLE = no response outstanding, RESP = one response being presented.
   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } arb_state_e;

   // Requester IDs: m0 is the IFU fetch port, m1 is the LSU read port.
   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   // One-hot grant vector to requester ID; an empty grant decodes to M0 and is never
   // used as a winner because callers qualify it with |gnt.
   function automatic logic gnt_to_id(input logic [1:0] gnt);
      return gnt[1] ? M1 : M0;
   endfunction

endpackage

// File: rtl/ysyx_22050710_arb2.sv
// ysyx_22050710_arb2: combinational two-way request arbiter producing a one-hot grant.
// Build option YSYX_22050710_SRAM_ARB_RR_EN:
//   defined   -> round-robin, i_ptr names the requester preferred this cycle
//   undefined -> fixed priority, m1 (LSU) over m0 (IFU); i_ptr is ignored
module ysyx_22050710_arb2
   import ysyx_22050710_sram_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_ptr,
   output logic [1:0] o_gnt
);

`ifdef YSYX_22050710_SRAM_ARB_RR_EN

   // Round-robin: the preferred requester wins if it asks, otherwise the other one does.
   // NOTE: every signal written in an always_comb gets a default first so that no
   // path through the block leaves it unassigned and infers a latch.
   always_comb begin
      o_gnt = 2'b00;
      if (i_ptr == M0) begin
         if (i_req[0])      o_gnt = 2'b01;
         else if (i_req[1]) o_gnt = 2'b10;
      end else begin
         if (i_req[1])      o_gnt = 2'b10;
         else if (i_req[0]) o_gnt = 2'b01;
      end
   end

`else

   // The pointer has no meaning for fixed priority; it is consumed here only so the
   // port list stays identical between the two builds.
   logic unused_ptr;
   assign unused_ptr = i_ptr;

   // Fixed priority: the LSU (m1) always beats the IFU (m0).
   always_comb begin
      o_gnt = 2'b00;
      if (i_req[1])      o_gnt = 2'b10;
      else if (i_req[0]) o_gnt = 2'b01;
   end

`endif

endmodule

// File: rtl/ysyx_22050710_sram_rd_arbiter.sv
// ysyx_22050710_sram_rd_arbiter: shares the single read port of the 1-cycle-latency
// instruction SRAM between the IFU (m0) and the LSU (m1). One request is granted per
// cycle, the read is issued to the SRAM in the grant cycle, and the returned word is
// presented to its owner on the following cycle and held until the owner accepts it.
// A new grant may coincide with the response handshake, giving one read per cycle.
// Build option YSYX_22050710_SRAM_ARB_RR_EN selects round-robin arbitration; without
// it the LSU has fixed priority over the IFU.
module ysyx_22050710_sram_rd_arbiter
   import ysyx_22050710_sram_arb_pkg::*;
#(
   parameter int SRAM_ADDR_WD = 32,
   parameter int SRAM_DATA_WD = 64
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   // m0: IFU fetch
   input  logic                    i_m0_arvalid,
   output logic                    o_m0_arready,
   input  logic [SRAM_ADDR_WD-1:0] i_m0_araddr,
   output logic                    o_m0_rvalid,
   input  logic                    i_m0_rready,
   output logic [SRAM_DATA_WD-1:0] o_m0_rdata,
   // m1: LSU read
   input  logic                    i_m1_arvalid,
   output logic                    o_m1_arready,
   input  logic [SRAM_ADDR_WD-1:0] i_m1_araddr,
   output logic                    o_m1_rvalid,
   input  logic                    i_m1_rready,
   output logic [SRAM_DATA_WD-1:0] o_m1_rdata,
   // SRAM read port
   output logic                    o_sram_ren,
   output logic [SRAM_ADDR_WD-1:0] o_sram_addr,
   input  logic [SRAM_DATA_WD-1:0] i_sram_rdata
);

   arb_state_e state;
   arb_state_e state_nxt;
   logic       owner;         // requester whose response is (or will be) presented
   logic       owner_nxt;
   logic       ptr;           // requester preferred by the arbiter this cycle
   logic [1:0] req;
   logic [1:0] arb_gnt;       // raw arbiter decision, before qualification
   logic [1:0] gnt;           // grant that actually handshakes this cycle
   logic       win;
   logic       owner_rready;
   logic       arb_open;

   assign req          = {i_m1_arvalid, i_m0_arvalid};
   assign owner_rready = (owner == M1) ? i_m1_rready : i_m0_rready;

   // A new read may only be issued while the SRAM output is free: either nothing is
   // outstanding, or the outstanding word is being consumed this very cycle. The
   // window is also closed while reset is asserted, so no requester sees a handshake
   // that the cleared FSM would then forget.
   assign arb_open = i_rst_n && ((state == IDLE) || owner_rready);
   assign gnt      = arb_open ? arb_gnt : 2'b00;
   assign win      = gnt_to_id(gnt);

   ysyx_22050710_arb2 u_arb2 (
      .i_req (req),
      .i_ptr (ptr),
      .o_gnt (arb_gnt)
   );

`ifdef YSYX_22050710_SRAM_ARB_RR_EN

   logic rr_ptr;

   // Round-robin pointer: after every grant the requester that lost is preferred next.
   // NOTE: sequential state is always written with non-blocking assignments so every
   // flop samples the pre-edge value of every other flop, independent of block order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rr_ptr <= M0;
      end else if (|gnt) begin
         rr_ptr <= ~win;
      end
   end

   assign ptr = rr_ptr;

`else

   // Fixed priority needs no history; the arbiter ignores this input.
   assign ptr = M0;

`endif

   // FSM state and response owner registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
         owner <= M0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
      end
   end

   // Next-state logic plus request-side and response-side output decode.
   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;

      // Request side: the qualified grant drives arready, ren and the address mux.
      o_m0_arready = gnt[0];
      o_m1_arready = gnt[1];
      o_sram_ren   = |gnt;
      o_sram_addr  = '0;
      if (gnt[1]) begin
         o_sram_addr = i_m1_araddr;
      end else if (gnt[0]) begin
         o_sram_addr = i_m0_araddr;
      end

      // Response side: a pure state/owner decode, with no path from any arvalid.
      o_m0_rvalid  = 1'b0;
      o_m1_rvalid  = 1'b0;
      o_m0_rdata   = '0;
      o_m1_rdata   = '0;

      case (state)
         IDLE: begin
            if (|gnt) begin
               state_nxt = RESP;
               owner_nxt = win;
            end
         end
         RESP: begin
            // The SRAM keeps its registered output while ren is low, so the word is
            // stable for as long as the owner stalls.
            if (owner == M1) begin
               o_m1_rvalid = 1'b1;
               o_m1_rdata  = i_sram_rdata;
            end else begin
               o_m0_rvalid = 1'b1;
               o_m0_rdata  = i_sram_rdata;
            end
            if (owner_rready) begin
               if (|gnt) begin
                  owner_nxt = win;      // back-to-back: next word follows directly
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Protocol sanity: at most one response is presented, and a read is issued exactly
   // when one requester handshakes its address.
   a_single_rvalid : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(o_m0_rvalid && o_m1_rvalid));
   a_ren_is_handshake : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      o_sram_ren == (o_m0_arready || o_m1_arready));
   a_single_grant : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(o_m0_arready && o_m1_arready));

endmodule
